// File: rtl/bvh_fetch_arbiter.sv
// bvh_fetch_arbiter: shares one fixed-latency BVH memory read port between
// NUM_REQ traversal requesters. Round-robin grant, one outstanding fetch per
// requester, response routed back through a MEM_LAT-deep tag pipeline.
// Optional build macro: BVH_ARB_COALESCE_EN -- requesters asking for the same
// node index as the round-robin winner are granted alongside it and share
// the single memory read.
module bvh_fetch_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 16,
  parameter int DATA_W  = 256,
  parameter int MEM_LAT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     mem_rd_en,
  output logic [IDX_W-1:0]         mem_rd_addr,
  input  logic [DATA_W-1:0]        mem_rd_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] tag_q [MEM_LAT];
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [NUM_REQ-1:0] tag_exit_s;
  logic [PTR_W-1:0]   winner_s;
  logic [PTR_W-1:0]   cand_s;
  logic               found_s;
  logic               hit_s;
  logic [IDX_W-1:0]   idx_arr_s [NUM_REQ];
  logic [IDX_W-1:0]   win_idx_s;

  // Round-robin winner search, grant vector, memory request and next state.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_arr_s[i] = req_idx[i*IDX_W +: IDX_W];
    end
    // No grants while reset is held, so nothing enters the tag pipe.
    elig_s   = reset ? {NUM_REQ{1'b0}} : (req & ~pend_q);
    found_s  = 1'b0;
    winner_s = {PTR_W{1'b0}};
    cand_s   = {PTR_W{1'b0}};
    hit_s    = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s   = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      hit_s    = ~found_s & elig_s[cand_s];
      winner_s = hit_s ? cand_s : winner_s;
      found_s  = found_s | hit_s;
    end
    win_idx_s = idx_arr_s[winner_s];

    gnt_s           = {NUM_REQ{1'b0}};
    gnt_s[winner_s] = found_s;
`ifdef BVH_ARB_COALESCE_EN
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt_s[j] = gnt_s[j] | (found_s & elig_s[j] & (idx_arr_s[j] == win_idx_s));
    end
`else
    gnt_s = gnt_s;
`endif

    gnt         = gnt_s;
    mem_rd_en   = found_s;
    mem_rd_addr = found_s ? win_idx_s : {IDX_W{1'b0}};

    // Pointer advances past the round-robin winner only, even when coalescing.
    rr_ptr_d   = found_s ? PTR_W'((int'(winner_s) + 1) % NUM_REQ) : rr_ptr_q;
    tag_exit_s = tag_q[MEM_LAT-1];
    // A new grant sets pend; set takes priority over the response clear.
    pend_d     = (pend_q & ~tag_exit_s) | gnt_s;
  end

  // State registers: pointer, pending mask, tag pipe and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= {PTR_W{1'b0}};
      pend_q      <= {NUM_REQ{1'b0}};
      rsp_valid_q <= {NUM_REQ{1'b0}};
      rsp_data_q  <= {DATA_W{1'b0}};
      for (int s = 0; s < MEM_LAT; s++) begin
        tag_q[s] <= {NUM_REQ{1'b0}};
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      tag_q[0] <= gnt_s;
      for (int s = 1; s < MEM_LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
      rsp_valid_q <= tag_exit_s;
      // Data is only captured for a live tag; otherwise the last word is held.
      if (tag_exit_s != {NUM_REQ{1'b0}}) begin
        rsp_data_q <= mem_rd_data;
      end else begin
        rsp_data_q <= rsp_data_q;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bvh_fetch_arbiter.sv
// Self-checking bench for bvh_fetch_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model
// and a response scoreboard.
module tb_bvh_fetch_arbiter;
  localparam int N  = 4;
  localparam int IW = 16;
  localparam int DW = 256;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*IW-1:0] req_idx = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_rd_en;
  logic [IW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_data;

  bvh_fetch_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW), .MEM_LAT(L)) dut (
    .clk(clk), .reset(reset), .req(req), .req_idx(req_idx), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit run = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [IW-1:0] a);
    logic [DW-1:0] w;
    for (int k = 0; k < DW/32; k++)
      w[k*32 +: 32] = ({16'h0, a} * 32'h9E3779B1) ^ (32'(k) * 32'h01010101) ^ 32'h5A5A0000;
    return w;
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [N*IW-1:0] v, input int i);
    return v[i*IW +: IW];
  endfunction

  // Cycle counter shared by model and monitor.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: data appears exactly L cycles after the read enable,
  // random junk at all other times.
  logic [IW-1:0] apipe [L];
  logic          vpipe [L];
  logic [DW-1:0] junk = '0;
  initial for (int s = 0; s < L; s++) begin apipe[s] = '0; vpipe[s] = 1'b0; end
  always @(posedge clk) begin
    apipe[0] <= mem_rd_addr;
    vpipe[0] <= mem_rd_en;
    for (int s = 1; s < L; s++) begin apipe[s] <= apipe[s-1]; vpipe[s] <= vpipe[s-1]; end
    for (int k = 0; k < DW/32; k++) junk[k*32 +: 32] <= $urandom;
  end
  assign mem_rd_data = vpipe[L-1] ? mem_word(apipe[L-1]) : junk;

  typedef struct {
    int           due;
    logic [N-1:0] mask;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: requester i is busy until the cycle its response shows.
  int           busy_until [N];
  int           rr = 0;
  logic [N-1:0] m_el, m_eg;
  int           m_w;
  initial for (int i = 0; i < N; i++) busy_until[i] = 0;

  always @(negedge clk) begin
    if (run) begin
      if (reset) begin
        check("gnt_in_reset", DW'(gnt), DW'(0));
        check("mem_rd_en_in_reset", DW'(mem_rd_en), DW'(0));
        for (int q = sb_q.size() - 1; q >= 0; q--)
          if (sb_q[q].due > cyc) sb_q.delete(q);
        for (int i = 0; i < N; i++) busy_until[i] = 0;
        rr = 0;
      end else begin
        for (int i = 0; i < N; i++) m_el[i] = req[i] && (cyc >= busy_until[i]);
        m_w = -1;
        for (int k = 0; k < N; k++)
          if (m_w < 0 && m_el[(rr + k) % N]) m_w = (rr + k) % N;
        m_eg = '0;
        if (m_w >= 0) begin
          m_eg[m_w] = 1'b1;
`ifdef BVH_ARB_COALESCE_EN
          for (int j = 0; j < N; j++)
            if (m_el[j] && idx_of(req_idx, j) == idx_of(req_idx, m_w)) m_eg[j] = 1'b1;
`endif
        end
        check("gnt", DW'(gnt), DW'(m_eg));
        check("mem_rd_en", DW'(mem_rd_en), DW'(m_w >= 0));
        if (m_w >= 0) begin
          check("mem_rd_addr", DW'(mem_rd_addr), DW'(idx_of(req_idx, m_w)));
          for (int j = 0; j < N; j++) if (m_eg[j]) busy_until[j] = cyc + L + 1;
          rr = (m_w + 1) % N;
          sb_q.push_back('{due: cyc + L + 1, mask: m_eg, data: mem_word(idx_of(req_idx, m_w))});
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a response is due.
  logic [DW-1:0] last_data = '0;
  exp_t          e;
  always @(negedge clk) begin
    if (run) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        e = sb_q.pop_front();
        check("rsp_valid", DW'(rsp_valid), DW'(e.mask));
        check("rsp_data", rsp_data, e.data);
        last_data = e.data;
      end else begin
        check("rsp_valid_idle", DW'(rsp_valid), DW'(0));
        check("rsp_data_hold", rsp_data, last_data);
      end
      if (reset) last_data = '0;
    end
  end

  // Grant seen in the previous cycle, used by the requesters to drop req.
  logic [N-1:0] gnt_last = '0;
  always @(negedge clk) gnt_last = gnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) tick();
  endtask

  task automatic hold_until(input logic [N-1:0] m, input logic [N*IW-1:0] idxv);
    logic [N-1:0] done;
    done = '0;
    req_idx = idxv;
    req = m;
    for (int n = 0; n < 30 && req != '0; n++) begin
      tick();
      done |= gnt_last;
      req = m & ~done;
    end
    check("hold_timeout", DW'(req), DW'(0));
    req = '0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    run = 1'b1;
    idle(10);
    // Single fetch of node 0x12 from requester 0.
    hold_until(4'b0001, {16'h0, 16'h0, 16'h0, 16'h0012});
    idle(5);
    // Pointer sits at 1: requesters 3 and 0 -> 3 first, then wrap to 0.
    hold_until(4'b1001, {16'h0031, 16'h0, 16'h0, 16'h0030});
    idle(5);
    // Two requesters asking for the same node.
    hold_until(4'b0011, {16'h0, 16'h0, 16'h0040, 16'h0040});
    idle(5);
    // Grant, then reset while the read is in flight.
    req_idx = {16'h0, 16'h0077, 16'h0, 16'h0};
    req = 4'b0100;
    tick();
    req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(6);
    // Pointer must be back at 0: requester 1 wins before 3.
    hold_until(4'b1010, {16'h0013, 16'h0, 16'h0011, 16'h0});
    idle(5);
    // Randomized traffic with small index set to provoke equal indices.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !gnt_last[i]) begin
          if ($urandom % 16 == 0) req[i] = 1'b0;
          else if ($urandom % 8 == 0) req_idx[i*IW +: IW] = 16'($urandom_range(0, 7));
        end else begin
          req[i] = ($urandom % 4) != 0;
          req_idx[i*IW +: IW] = 16'($urandom_range(0, 7));
        end
      end
      reset = ($urandom % 300) == 0;
      tick();
    end
    reset = 1'b0;
    req = '0;
    for (int n = 0; n < 20 && sb_q.size() > 0; n++) tick();
    check("drain_pending", DW'(sb_q.size()), DW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
